// File: rtl/alu_flag_unit.sv
// 6502/65Org16 status register stage: deferred ALU flag update plus immediate flag ops.
// Define ALU_FLAG_FWD_EN to forward a pending ALU flag update onto the flag outputs.
module alu_flag_unit #(
  parameter int dw = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          RDY,
  input  logic [3:0]    upd_op,
  input  logic          alu_co,
  input  logic          alu_v,
  input  logic          alu_z,
  input  logic          alu_n,
  input  logic [dw-1:0] db_in,
  input  logic          brk,
  output logic [7:0]    p_out,
  output logic [7:0]    p_push,
  output logic          flag_c,
  output logic          flag_z,
  output logic          flag_n,
  output logic          flag_v,
  output logic          flag_d,
  output logic          flag_i
);

  localparam logic [3:0] OP_NZ   = 4'h1;
  localparam logic [3:0] OP_NZC  = 4'h2;
  localparam logic [3:0] OP_NVZC = 4'h3;
  localparam logic [3:0] OP_BIT  = 4'h4;
  localparam logic [3:0] OP_PLP  = 4'h5;
  localparam logic [3:0] OP_CLC  = 4'h6;
  localparam logic [3:0] OP_SEC  = 4'h7;
  localparam logic [3:0] OP_CLI  = 4'h8;
  localparam logic [3:0] OP_SEI  = 4'h9;
  localparam logic [3:0] OP_CLD  = 4'hA;
  localparam logic [3:0] OP_SED  = 4'hB;
  localparam logic [3:0] OP_CLV  = 4'hC;

  logic       r_c, r_z, r_i, r_d, r_v, r_n;
  logic       r_pend;
  logic [3:0] r_mask;

  logic       w_def;
  logic [3:0] w_dmask;
  logic       w_c, w_z, w_v, w_n;
  logic       w_unused;

  // mask order is {N,V,Z,C}
  always_comb begin
    w_def   = 1'b1;
    w_dmask = 4'b0000;
    case (upd_op)
      OP_NZ:   w_dmask = 4'b1010;
      OP_NZC:  w_dmask = 4'b1011;
      OP_NVZC: w_dmask = 4'b1111;
      OP_BIT:  w_dmask = 4'b0010;
      default: w_def   = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_c    <= 1'b0;
      r_z    <= 1'b0;
      r_i    <= 1'b1;
      r_d    <= 1'b0;
      r_v    <= 1'b0;
      r_n    <= 1'b0;
      r_pend <= 1'b0;
      r_mask <= 4'b0000;
    end else if (RDY) begin
      // older pending ALU result first; the immediate op below overrides it
      if (r_pend) begin
        if (r_mask[3]) r_n <= alu_n;
        if (r_mask[2]) r_v <= alu_v;
        if (r_mask[1]) r_z <= alu_z;
        if (r_mask[0]) r_c <= alu_co;
      end
      case (upd_op)
        OP_BIT: begin
          r_n <= db_in[dw-1];
          r_v <= db_in[dw-2];
        end
        OP_PLP: begin
          r_c <= db_in[0];
          r_z <= db_in[1];
          r_i <= db_in[2];
          r_d <= db_in[3];
          r_v <= db_in[6];
          r_n <= db_in[7];
        end
        OP_CLC: r_c <= 1'b0;
        OP_SEC: r_c <= 1'b1;
        OP_CLI: r_i <= 1'b0;
        OP_SEI: r_i <= 1'b1;
        OP_CLD: r_d <= 1'b0;
        OP_SED: r_d <= 1'b1;
        OP_CLV: r_v <= 1'b0;
        default: ;
      endcase
      r_pend <= w_def;
      r_mask <= w_dmask;
    end
  end

`ifdef ALU_FLAG_FWD_EN
  assign w_c = (r_pend && r_mask[0]) ? alu_co : r_c;
  assign w_z = (r_pend && r_mask[1]) ? alu_z  : r_z;
  assign w_v = (r_pend && r_mask[2]) ? alu_v  : r_v;
  assign w_n = (r_pend && r_mask[3]) ? alu_n  : r_n;
`else
  assign w_c = r_c;
  assign w_z = r_z;
  assign w_v = r_v;
  assign w_n = r_n;
`endif

  assign flag_c = w_c;
  assign flag_z = w_z;
  assign flag_v = w_v;
  assign flag_n = w_n;
  assign flag_d = r_d;
  assign flag_i = r_i;

  assign p_out  = {w_n, w_v, 1'b1, 1'b1, r_d, r_i, w_z, w_c};
  assign p_push = {w_n, w_v, 1'b1, brk,  r_d, r_i, w_z, w_c};

  assign w_unused = ^db_in;

endmodule

// File: tb/tb_alu_flag_unit.sv
// Bench for alu_flag_unit: directed literal checks plus randomized run vs a queue-based model.
// Honours ALU_FLAG_FWD_EN the same way as the design.
module tb_alu_flag_unit;

`ifdef ALU_FLAG_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, RDY, alu_co, alu_v, alu_z, alu_n, brk;
  logic [3:0]  upd_op;
  logic [15:0] db_in;
  logic [7:0]  p_out, p_push;
  logic        flag_c, flag_z, flag_n, flag_v, flag_d, flag_i;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  alu_flag_unit #(.dw(16)) dut (
    .clk(clk), .reset(reset), .RDY(RDY), .upd_op(upd_op),
    .alu_co(alu_co), .alu_v(alu_v), .alu_z(alu_z), .alu_n(alu_n),
    .db_in(db_in), .brk(brk), .p_out(p_out), .p_push(p_push),
    .flag_c(flag_c), .flag_z(flag_z), .flag_n(flag_n),
    .flag_v(flag_v), .flag_d(flag_d), .flag_i(flag_i)
  );

  always #5 clk = ~clk;

  // model: P as a byte image, pending updates as a queue of {N,V,Z,C} masks
  bit [7:0] m_p;
  bit [3:0] pq[$];

  function automatic bit [3:0] mask_of(input int op);
    case (op)
      1: return 4'b1010;
      2: return 4'b1011;
      3: return 4'b1111;
      4: return 4'b0010;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic bit [7:0] with_alu(input bit [7:0] p, input bit [3:0] mk);
    bit [7:0] r;
    r = p;
    if (mk[3]) r[7] = alu_n;
    if (mk[2]) r[6] = alu_v;
    if (mk[1]) r[1] = alu_z;
    if (mk[0]) r[0] = alu_co;
    return r;
  endfunction

  task automatic model_step();
    int op;
    op = int'(upd_op);
    if (reset) begin
      m_p = 8'h34;
      pq.delete();
    end else if (RDY) begin
      if (pq.size() > 0) m_p = with_alu(m_p, pq.pop_front());
      case (op)
        4: begin m_p[7] = db_in[15]; m_p[6] = db_in[14]; end
        5: m_p = (db_in[7:0] & 8'hCF) | 8'h30;
        6: m_p[0] = 1'b0;
        7: m_p[0] = 1'b1;
        8: m_p[2] = 1'b0;
        9: m_p[2] = 1'b1;
        10: m_p[3] = 1'b0;
        11: m_p[3] = 1'b1;
        12: m_p[6] = 1'b0;
        default: ;
      endcase
      if (mask_of(op) != 4'b0000) pq.push_back(mask_of(op));
    end
  endtask

  function automatic bit [7:0] exp_p();
    if (FWD && pq.size() > 0) return with_alu(m_p, pq[0]);
    return m_p;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      bit [7:0] e;
      bit [21:0] ev, av;
      e = exp_p();
      ev = {e, e[7:6], 1'b1, brk, e[3:0], e[7], e[6], e[3], e[2], e[1], e[0]};
      av = {p_out, p_push, flag_n, flag_v, flag_d, flag_i, flag_z, flag_c};
      total++;
      if (av !== ev) begin
        bad++;
        $display("FAIL model t=%0t got %h want %h", $time, av, ev);
      end
    end
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit rs, input bit rd, input int op,
                       input bit co, input bit v, input bit z, input bit n,
                       input logic [15:0] db);
    reset = rs; RDY = rd; upd_op = 4'(op);
    alu_co = co; alu_v = v; alu_z = z; alu_n = n;
    db_in = db;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    brk = 1'b0;
    drive(1, 1, 0, 0, 0, 0, 0, 16'h0);
    tick();
    chk_en = 1'b1;
    tick();
    // SEC with RDY low must be ignored
    drive(0, 0, 7, 1, 1, 1, 1, 16'hFFFF);
    tick();
    chk("reset_p", p_out, 8'h34);
    chk("reset_i", {7'd0, flag_i}, 8'h01);
    chk("reset_c", {7'd0, flag_c}, 8'h00);

    drive(0, 1, 3, 0, 0, 0, 0, 16'h0);
    tick();
    drive(0, 1, 0, 1, 1, 0, 1, 16'h0);
    #1 chk("nvzc_fwd_c", {7'd0, flag_c}, {7'd0, FWD});
    tick();
    drive(0, 1, 0, 0, 0, 0, 0, 16'h0);
    #1 chk("nvzc_p", p_out, 8'hF5);

    drive(0, 1, 5, 0, 0, 0, 0, 16'h00FF);
    tick();
    chk("plp_ff", p_out, 8'hFF);
    drive(0, 1, 5, 0, 0, 0, 0, 16'h0000);
    tick();
    chk("plp_00", p_out, 8'h30);
    chk("push_00", p_push, 8'h20);

    drive(0, 1, 4, 0, 0, 0, 0, 16'h8000);
    tick();
    drive(0, 1, 0, 0, 0, 1, 0, 16'h0);
    #1 chk("bit_nv", {6'd0, flag_n, flag_v}, 8'h02);
    tick();
    drive(0, 1, 0, 0, 0, 0, 0, 16'h0);
    #1 chk("bit_z", {7'd0, flag_z}, 8'h01);

    drive(0, 1, 2, 0, 0, 0, 0, 16'h0);
    tick();
    drive(0, 0, 0, 1, 0, 0, 0, 16'h0);
    for (int k = 0; k < 3; k++) begin
      #1 chk("stall_c", {7'd0, flag_c}, {7'd0, FWD});
      tick();
    end
    drive(0, 1, 0, 1, 0, 0, 0, 16'h0);
    tick();
    drive(0, 1, 0, 0, 0, 0, 0, 16'h0);
    #1 chk("stall_apply_c", {7'd0, flag_c}, 8'h01);

    drive(0, 1, 3, 0, 0, 0, 0, 16'h0);
    tick();
    drive(0, 1, 6, 1, 1, 1, 0, 16'h0);
    tick();
    drive(0, 1, 0, 0, 0, 0, 0, 16'h0);
    #1 chk("clc_wins", {flag_n, flag_v, 4'd0, flag_z, flag_c}, 8'h42);

    drive(0, 1, 3, 0, 0, 0, 0, 16'h0);
    tick();
    drive(1, 1, 0, 1, 1, 1, 1, 16'h0);
    tick();
    drive(0, 0, 0, 1, 1, 1, 1, 16'h0);
    #1 chk("reset_mid", p_out, 8'h34);

    for (int k = 0; k < 3000; k++) begin
      drive($urandom_range(63) == 0, $urandom_range(3) != 0,
            $urandom_range(15), $urandom_range(1), $urandom_range(1),
            $urandom_range(1), $urandom_range(1), 16'($urandom));
      brk = $urandom_range(1);
      tick();
    end

    @(negedge clk);
    chk_en = 1'b0;
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
